mouse_cursor_plotter: RTL and testbench

- Bus master that sits directly upstream of the VGA frame-buffer peripheral (bus base 0xB0).
- Converts mouse position updates into bus write bursts to that peripheral: it erases the previously drawn cursor square, then draws the new one.
- Shares the 8-bit data bus with the processor through a request/grant pair; the top level owns the tristate.

---
 rtl/mouse_vga_pkg.sv | 26 ++
 rtl/vga_pixel_writer.sv | 72 +++++++
 rtl/mouse_cursor_plotter.sv | 191 +++++++++++++++++++
 tb/tb_mouse_cursor_plotter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_vga_pkg.sv
// Shared definitions for the mouse cursor plotter: VGA register offsets,
// controller state encoding and pixel-burst slot encoding.
package mouse_vga_pkg;

  // Register offsets from the VGA peripheral base address
  localparam logic [7:0] OFS_X = 8'd0;
  localparam logic [7:0] OFS_Y = 8'd1;
  localparam logic [7:0] OFS_P = 8'd2;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ERASE = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Slot inside one three-write pixel burst
  typedef enum logic [1:0] {
    SLOT_X = 2'd0,
    SLOT_Y = 2'd1,
    SLOT_P = 2'd2
  } slot_t;

endpackage

// File: rtl/vga_pixel_writer.sv
// Issues one pixel as a three-write burst (X, Y, pixel value) to the VGA
// peripheral. A slot is written only in a cycle where start and gnt are
// both high; when gnt drops the current slot is held and resumed later, so
// every slot is written exactly once.
//
// Handshake: start is a level held by the caller with stable x/y/value
// until done; done pulses in the same cycle as the pixel-value write.
module vga_pixel_writer
  import mouse_vga_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hB0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       value,
  input  logic       gnt,
  output logic       done,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic       we
);

  slot_t slot_q;
  logic  write_now;

  assign write_now = start & gnt;
  assign we        = write_now;
  assign done      = write_now && (slot_q == SLOT_P);

  // Address/data mux: bus is driven to zero outside write cycles
  always_comb begin
    addr = 8'h00;
    data = 8'h00;
    if (write_now) begin
      case (slot_q)
        SLOT_X: begin
          addr = BASE_ADDR + OFS_X;
          data = x;
        end
        SLOT_Y: begin
          addr = BASE_ADDR + OFS_Y;
          data = y;
        end
        SLOT_P: begin
          addr = BASE_ADDR + OFS_P;
          data = {7'b0, value};
        end
        default: begin
          addr = 8'h00;
          data = 8'h00;
        end
      endcase
    end
  end

  // Slot sequencer: advances only on a completed write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT_X;
    end else if (write_now) begin
      case (slot_q)
        SLOT_X:  slot_q <= SLOT_Y;
        SLOT_Y:  slot_q <= SLOT_P;
        default: slot_q <= SLOT_X;
      endcase
    end
  end

endmodule

// File: rtl/mouse_cursor_plotter.sv
// Bus master that turns mouse position updates into VGA frame-buffer writes:
// erase the previously drawn cursor square, then draw the new one. Owns the
// pending/old-position registers, the i/j pixel walk and the clipping.
module mouse_cursor_plotter
  import mouse_vga_pkg::*;
#(
  parameter logic [7:0] VGA_BASE_ADDR = 8'hB0,
  parameter int         X_LIMIT       = 160,
  parameter int         Y_LIMIT       = 120,
  parameter int         CURSOR_SIZE   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] MOUSE_X,
  input  logic [7:0] MOUSE_Y,
  input  logic       MOUSE_VALID,
  input  logic       BUS_GNT,
  output logic       BUS_REQ,
  output logic [7:0] BUS_ADDR,
  output logic [7:0] BUS_DATA_OUT,
  output logic       BUS_DATA_OE,
  output logic       BUS_WE,
  output logic       BUSY,
  output state_t     dbg_state
);

  localparam logic [8:0] X_LIM   = 9'(X_LIMIT);
  localparam logic [8:0] Y_LIM   = 9'(Y_LIMIT);
  localparam logic [2:0] SIZE_M1 = 3'(CURSOR_SIZE - 1);

  state_t     state_q, state_d;
  logic       pending_q;
  logic [7:0] pend_x_q, pend_y_q;
  logic [7:0] new_x_q, new_y_q;
  logic [7:0] old_x_q, old_y_q;
  logic       drawn_q;
  logic [2:0] i_q, j_q;

  logic       pend_clr, take_new, walk_rst, commit, bus_req;
  logic [7:0] cur_x, cur_y;
  logic [8:0] px, py;
  logic       in_walk, clip, last_pix;
  logic       pix_start, pix_done, pix_adv;
  logic       we;

  // Current pixel: old square while erasing, new square while drawing.
  // Sums are 9 bits wide so a coordinate of 8'hFF plus an offset does not wrap.
  always_comb begin
    cur_x     = (state_q == ST_ERASE) ? old_x_q : new_x_q;
    cur_y     = (state_q == ST_ERASE) ? old_y_q : new_y_q;
    px        = {1'b0, cur_x} + {6'b0, i_q};
    py        = {1'b0, cur_y} + {6'b0, j_q};
    in_walk   = (state_q == ST_ERASE) || (state_q == ST_DRAW);
    clip      = (px >= X_LIM) || (py >= Y_LIM);
    last_pix  = (i_q == SIZE_M1) && (j_q == SIZE_M1);
    pix_start = in_walk && !clip;
    // A clipped pixel costs exactly one idle cycle, regardless of grant
    pix_adv   = in_walk && (clip || pix_done);
  end

  // Next-state and control decode
  always_comb begin
    state_d  = state_q;
    pend_clr = 1'b0;
    take_new = 1'b0;
    walk_rst = 1'b0;
    commit   = 1'b0;
    bus_req  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          pend_clr = 1'b1;
          if (!(drawn_q && pend_x_q == old_x_q && pend_y_q == old_y_q)) begin
            take_new = 1'b1;
            state_d  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        bus_req = 1'b1;
        if (BUS_GNT) begin
          walk_rst = 1'b1;
          state_d  = drawn_q ? ST_ERASE : ST_DRAW;
        end
      end
      ST_ERASE: begin
        bus_req = 1'b1;
        if (pix_adv && last_pix) begin
          walk_rst = 1'b1;
          state_d  = ST_DRAW;
        end
      end
      ST_DRAW: begin
        bus_req = 1'b1;
        if (pix_adv && last_pix) begin
          commit  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Pending update capture; a new strobe wins over a same-cycle clear
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pending_q <= 1'b0;
      pend_x_q  <= 8'h00;
      pend_y_q  <= 8'h00;
    end else if (MOUSE_VALID) begin
      pending_q <= 1'b1;
      pend_x_q  <= MOUSE_X;
      pend_y_q  <= MOUSE_Y;
    end else if (pend_clr) begin
      pending_q <= 1'b0;
    end
  end

  // Target and drawn-cursor position registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      new_x_q <= 8'h00;
      new_y_q <= 8'h00;
      old_x_q <= 8'h00;
      old_y_q <= 8'h00;
      drawn_q <= 1'b0;
    end else begin
      if (take_new) begin
        new_x_q <= pend_x_q;
        new_y_q <= pend_y_q;
      end
      if (commit) begin
        old_x_q <= new_x_q;
        old_y_q <= new_y_q;
        drawn_q <= 1'b1;
      end
    end
  end

  // Row-major walk over the square: i inner (X), j outer (Y)
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      i_q <= 3'd0;
      j_q <= 3'd0;
    end else if (walk_rst) begin
      i_q <= 3'd0;
      j_q <= 3'd0;
    end else if (pix_adv) begin
      if (i_q == SIZE_M1) begin
        i_q <= 3'd0;
        j_q <= j_q + 3'd1;
      end else begin
        i_q <= i_q + 3'd1;
      end
    end
  end

  vga_pixel_writer #(
    .BASE_ADDR (VGA_BASE_ADDR)
  ) u_writer (
    .clk   (CLK),
    .rst_n (RESET),
    .start (pix_start),
    .x     (px[7:0]),
    .y     (py[7:0]),
    .value (state_q == ST_DRAW),
    .gnt   (BUS_GNT),
    .done  (pix_done),
    .addr  (BUS_ADDR),
    .data  (BUS_DATA_OUT),
    .we    (we)
  );

  assign BUS_WE      = we;
  assign BUS_DATA_OE = we;
  assign BUS_REQ     = bus_req;
  assign BUSY        = pending_q || (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mouse_cursor_plotter.sv
// Self-checking bench for mouse_cursor_plotter: directed scenarios plus
// randomized updates with random grant drops, checked by a scoreboard fed
// from a square-walk reference model.
module tb_mouse_cursor_plotter;
  import mouse_vga_pkg::*;

  localparam logic [7:0] BASE = 8'hB0;
  localparam int XL = 160;
  localparam int YL = 120;
  localparam int SZ = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mouse_x, mouse_y;
  logic       mouse_valid, bus_gnt;
  logic       bus_req, bus_data_oe, bus_we, busy;
  logic [7:0] bus_addr, bus_data_out;
  state_t     dbg_state;

  mouse_cursor_plotter #(
    .VGA_BASE_ADDR (BASE),
    .X_LIMIT       (XL),
    .Y_LIMIT       (YL),
    .CURSOR_SIZE   (SZ)
  ) dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .MOUSE_X      (mouse_x),
    .MOUSE_Y      (mouse_y),
    .MOUSE_VALID  (mouse_valid),
    .BUS_GNT      (bus_gnt),
    .BUS_REQ      (bus_req),
    .BUS_ADDR     (bus_addr),
    .BUS_DATA_OUT (bus_data_out),
    .BUS_DATA_OE  (bus_data_oe),
    .BUS_WE       (bus_we),
    .BUSY         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int wr_total  = 0;
  int draw_cyc  = 0;
  int erase_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expected write per WE cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (dbg_state == ST_DRAW)  draw_cyc++;
      if (dbg_state == ST_ERASE) erase_cyc++;
      check("oe_equals_we", {31'b0, bus_data_oe}, {31'b0, bus_we});
      if (bus_we) begin
        wr_total++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write (t=%0t)",
                   bus_addr, bus_data_out, $time);
        end else begin
          check("bus_write", {16'b0, bus_addr, bus_data_out}, {16'b0, exp_q.pop_front()});
        end
      end else begin
        check("idle_bus_zero", {16'b0, bus_addr, bus_data_out}, 32'h0);
      end
    end
  end

  // ---------------- reference model ----------------
  logic       m_drawn;
  logic [7:0] m_old_x, m_old_y;

  task automatic push_square(input logic [7:0] sx, input logic [7:0] sy, input logic v);
    int px, py;
    for (int j = 0; j < SZ; j++) begin
      for (int i = 0; i < SZ; i++) begin
        px = int'(sx) + i;
        py = int'(sy) + j;
        if (px < XL && py < YL) begin
          exp_q.push_back({BASE, 8'(px)});
          exp_q.push_back({BASE + 8'd1, 8'(py)});
          exp_q.push_back({BASE + 8'd2, 7'b0, v});
        end
      end
    end
  endtask

  task automatic model_update(input logic [7:0] nx, input logic [7:0] ny);
    if (m_drawn && nx == m_old_x && ny == m_old_y) return;
    if (m_drawn) push_square(m_old_x, m_old_y, 1'b0);
    push_square(nx, ny, 1'b1);
    m_drawn = 1'b1;
    m_old_x = nx;
    m_old_y = ny;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe leaves the task one step after the edge that sampled it
  task automatic issue_valid(input logic [7:0] x, input logic [7:0] y);
    tick();
    mouse_x     = x;
    mouse_y     = y;
    mouse_valid = 1'b1;
    tick();
    mouse_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rand_gnt);
    int n;
    n = 0;
    while (busy && n < budget) begin
      if (rand_gnt) bus_gnt = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    bus_gnt = 1'b1;
    check("idle_within_budget", {31'b0, (n < budget)}, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic wait_state(input state_t s, input int budget);
    int n;
    n = 0;
    while (dbg_state != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("reach_state", {29'b0, dbg_state}, {29'b0, s});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int w0, d0, e0, n;
    bit req_seen;
    logic [7:0] rx, ry;

    mouse_x = 8'h00; mouse_y = 8'h00; mouse_valid = 1'b0; bus_gnt = 1'b1;
    m_drawn = 1'b0; m_old_x = 8'h00; m_old_y = 8'h00;

    repeat (3) tick();
    check("reset_outputs", {12'b0, bus_req, bus_addr, bus_data_out, bus_data_oe, bus_we, busy}, 32'h0);
    rst_n = 1'b1;
    tick();

    // First draw with no erase, latency VALID -> REQ +1 -> WE +2
    w0 = wr_total;
    model_update(8'd10, 8'd20);
    issue_valid(8'd10, 8'd20);
    @(negedge clk);
    check("busy_after_valid", {31'b0, busy}, 32'd1);
    check("req_cycle0", {31'b0, bus_req}, 32'd0);
    @(negedge clk);
    check("req_cycle1", {31'b0, bus_req}, 32'd1);
    check("we_cycle1", {31'b0, bus_we}, 32'd0);
    @(negedge clk);
    check("first_we_cycle2", {31'b0, bus_we}, 32'd1);
    check("first_write", {16'b0, bus_addr, bus_data_out}, {16'b0, BASE, 8'd10});
    wait_idle(200, 1'b0);
    check("first_write_count", wr_total - w0, 32'd12);
    check("busy_low_after_done", {31'b0, busy}, 32'd0);

    // Erase + draw
    w0 = wr_total;
    model_update(8'd11, 8'd20);
    issue_valid(8'd11, 8'd20);
    wait_idle(200, 1'b0);
    check("erase_draw_count", wr_total - w0, 32'd24);

    // Corner pixel: one written, three clipped
    w0 = wr_total; d0 = draw_cyc; e0 = erase_cyc;
    model_update(8'd159, 8'd119);
    issue_valid(8'd159, 8'd119);
    wait_idle(200, 1'b0);
    check("corner_write_count", wr_total - w0, 32'd15);
    check("corner_draw_cycles", draw_cyc - d0, 32'd6);
    check("corner_erase_cycles", erase_cyc - e0, 32'd12);

    // Fully off-screen: no draw writes, four idle cycles
    w0 = wr_total; d0 = draw_cyc;
    model_update(8'd255, 8'd255);
    issue_valid(8'd255, 8'd255);
    wait_idle(200, 1'b0);
    check("offscreen_write_count", wr_total - w0, 32'd3);
    check("offscreen_draw_cycles", draw_cyc - d0, 32'd4);

    // Grant drop after the Y write of pixel 2
    w0 = wr_total;
    model_update(8'd20, 8'd30);
    issue_valid(8'd20, 8'd30);
    n = 0;
    while ((wr_total - w0) < 5 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reach_fifth_write", wr_total - w0, 32'd5);
    tick();
    bus_gnt = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("gnt_low_no_we", {31'b0, bus_we}, 32'd0);
      check("gnt_low_req_held", {31'b0, bus_req}, 32'd1);
      tick();
    end
    bus_gnt = 1'b1;
    @(negedge clk);
    check("resume_we", {31'b0, bus_we}, 32'd1);
    check("resume_slot_p", {24'b0, bus_addr}, {24'b0, BASE + 8'd2});
    wait_idle(200, 1'b0);
    check("gnt_drop_write_count", wr_total - w0, 32'd12);

    // Coalescing: three strobes during DRAW give one follow-on update
    model_update(8'd50, 8'd50);
    issue_valid(8'd50, 8'd50);
    wait_state(ST_DRAW, 100);
    issue_valid(8'd30, 8'd30);
    issue_valid(8'd31, 8'd30);
    issue_valid(8'd40, 8'd40);
    model_update(8'd40, 8'd40);
    wait_idle(400, 1'b0);

    // Same as drawn position: no bus request
    req_seen = 1'b0;
    issue_valid(8'd40, 8'd40);
    repeat (6) begin
      @(negedge clk);
      if (bus_req) req_seen = 1'b1;
    end
    check("same_pos_no_req", {31'b0, req_seen}, 32'd0);
    check("same_pos_busy_low", {31'b0, busy}, 32'd0);

    // Reset in the middle of an erase
    w0 = wr_total;
    model_update(8'd60, 8'd60);
    issue_valid(8'd60, 8'd60);
    n = 0;
    while (!(dbg_state == ST_ERASE && (wr_total - w0) >= 2) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reach_mid_erase", {29'b0, dbg_state}, {29'b0, ST_ERASE});
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {12'b0, bus_req, bus_addr, bus_data_out, bus_data_oe, bus_we, busy}, 32'h0);
    exp_q.delete();
    m_drawn = 1'b0; m_old_x = 8'h00; m_old_y = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    w0 = wr_total; e0 = erase_cyc;
    model_update(8'd70, 8'd70);
    issue_valid(8'd70, 8'd70);
    wait_idle(200, 1'b0);
    check("post_reset_no_erase", erase_cyc - e0, 32'd0);
    check("post_reset_write_count", wr_total - w0, 32'd12);

    // Randomized updates with random grant drops
    for (int k = 0; k < 25; k++) begin
      case ($urandom_range(0, 3))
        0: begin rx = 8'($urandom_range(0, 255)); ry = 8'($urandom_range(0, 255)); end
        1: begin rx = 8'($urandom_range(155, 165)); ry = 8'($urandom_range(115, 125)); end
        2: begin rx = m_old_x; ry = m_old_y; end
        default: begin rx = 8'($urandom_range(0, 159)); ry = 8'($urandom_range(0, 119)); end
      endcase
      model_update(rx, ry);
      issue_valid(rx, ry);
      wait_idle(600, 1'b1);
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
